ad7276_reader: RTL and testbench

SPI master that reads the AD7276 12-bit ADC on the NFC breakboard. It free-runs one conversion frame every FRAME_CYCLES clocks while enabled and delivers each result as a one-cycle valid pulse to the NFC-A demodulator. It runs in the 81.36 MHz core domain. With the defaults it produces 1.695 Msps, which is 2 samples per 847.5 kHz subcarrier period.

---
 rtl/ad7276_reader.sv | 137 +++++++++++++
 tb/tb_ad7276_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ad7276_reader.sv
// ad7276_reader
//    SPI master for the AD7276 12-bit ADC. While enabled it free-runs one
//    conversion frame every FRAME_CYCLES clocks. Each frame holds csn high for
//    CSN_HIGH clocks, then clocks 16 bits in MSB first with sclk idling high,
//    then delivers D11..D0 as a one-cycle sample_valid pulse.
//
//    The frame timeline is decoded from the current frame count and the result
//    is registered. Every output therefore shows the decode of the previous
//    count, one clock after that count.
//
// Ports
//    clk           core clock
//    rst           synchronous reset, active-high
//    en            level, 1 = run frames back to back
//    ad7276_csn    ADC chip select, active-low
//    ad7276_sclk   ADC serial clock, idles high
//    ad7276_sdata  ADC serial data
//    sample_valid  one-cycle pulse, sample is new
//    sample        last converted value, unsigned
//    frame_err     one-cycle pulse with sample_valid when a framing zero read 1
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | csn/sclk parked high, waiting for en
// ST_RUN  | fcnt sweeps 0..FRAME_CYCLES-1; wraps if en, else back to IDLE
module ad7276_reader #(
   parameter int FRAME_CYCLES = 48,
   parameter int CSN_HIGH     = 4,
   parameter int SCLK_HALF    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        ad7276_csn,
   output logic        ad7276_sclk,
   input  logic        ad7276_sdata,
   output logic        sample_valid,
   output logic [11:0] sample,
   output logic        frame_err
);

   localparam int FW = $clog2(FRAME_CYCLES);
   localparam logic [FW-1:0] LAST_C     = FW'(FRAME_CYCLES - 1);
   localparam logic [FW-1:0] CSN_HIGH_C = FW'(CSN_HIGH);
   localparam logic [FW-1:0] BIT_END_C  = FW'(CSN_HIGH + 32 * SCLK_HALF);
   localparam logic [FW-1:0] PERIOD_C   = FW'(2 * SCLK_HALF);
   localparam logic [FW-1:0] HALF_C     = FW'(SCLK_HALF);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t        state_q, state_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          csn_q, csn_d;
   logic          sclk_q, sclk_d;
   logic [15:0]   shift_q, shift_d;
   logic          valid_q, valid_d;
   logic [11:0]   sample_q, sample_d;
   logic          err_q, err_d;
   logic [FW-1:0] bit_off;

   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      csn_d    = 1'b1;
      sclk_d   = 1'b1;
      shift_d  = shift_q;
      valid_d  = 1'b0;
      sample_d = sample_q;
      err_d    = 1'b0;
      bit_off  = '0;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d = ST_RUN;
               fcnt_d  = '0;
            end
         end
         ST_RUN: begin
            if (fcnt_q == LAST_C) begin
               fcnt_d = '0;
               if (!en) begin
                  state_d = ST_IDLE;
               end
            end else begin
               fcnt_d = fcnt_q + FW'(1);
            end
            if ((fcnt_q >= CSN_HIGH_C) && (fcnt_q < BIT_END_C)) begin
               bit_off = fcnt_q - CSN_HIGH_C;
               csn_d   = 1'b0;
               // low half of each bit period first, then high half
               sclk_d  = (bit_off % PERIOD_C) >= HALF_C;
               // sample sdata on the same edge that drives sclk 0->1
               if (sclk_d && !sclk_q) begin
                  shift_d = {shift_q[14:0], ad7276_sdata};
               end
            end
            if (fcnt_q == BIT_END_C) begin
               valid_d  = 1'b1;
               sample_d = shift_q[13:2];
               err_d    = |{shift_q[15:14], shift_q[1:0]};
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         fcnt_q   <= '0;
         csn_q    <= 1'b1;
         sclk_q   <= 1'b1;
         shift_q  <= '0;
         valid_q  <= 1'b0;
         sample_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         fcnt_q   <= fcnt_d;
         csn_q    <= csn_d;
         sclk_q   <= sclk_d;
         shift_q  <= shift_d;
         valid_q  <= valid_d;
         sample_q <= sample_d;
         err_q    <= err_d;
      end
   end

   assign ad7276_csn   = csn_q;
   assign ad7276_sclk  = sclk_q;
   assign sample_valid = valid_q;
   assign sample       = sample_q;
   assign frame_err    = err_q;

endmodule

// File: tb/tb_ad7276_reader.sv
// Bench for ad7276_reader: default-parameter instance plus an instance with
// FRAME_CYCLES=40, CSN_HIGH=2. Each has a behavioural AD7276 model that shifts
// a framed 16-bit word out on falling sclk.
module tb_ad7276_reader;

   localparam int FC    = 48;
   localparam int CH    = 4;
   localparam int SH    = 1;
   localparam int LAT   = CH + 32 * SH + 1;
   localparam int FC_B  = 40;
   localparam int CH_B  = 2;
   localparam int LAT_B = CH_B + 32 * SH + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        en_b = 1'b0;
   logic        csn, sclk, valid, err;
   logic        sdata = 1'b0;
   logic [11:0] smp;
   logic        csn_b, sclk_b, valid_b, err_b;
   logic        sdata_b = 1'b0;
   logic [11:0] smp_b;

   always #5 clk = ~clk;

   ad7276_reader dut (
      .clk(clk), .rst(rst), .en(en),
      .ad7276_csn(csn), .ad7276_sclk(sclk), .ad7276_sdata(sdata),
      .sample_valid(valid), .sample(smp), .frame_err(err)
   );

   ad7276_reader #(.FRAME_CYCLES(FC_B), .CSN_HIGH(CH_B), .SCLK_HALF(SH)) dut_b (
      .clk(clk), .rst(rst), .en(en_b),
      .ad7276_csn(csn_b), .ad7276_sclk(sclk_b), .ad7276_sdata(sdata_b),
      .sample_valid(valid_b), .sample(smp_b), .frame_err(err_b)
   );

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_cmp = 0;
   int n_bad = 0;

   // ADC model A: word taken from adc_q at each csn rise
   logic [15:0] adc_word = 16'h0;
   logic [15:0] adc_q[$];
   int rises = 0, last_rises = 0, low_cnt = 0, last_low = 0, bad_rise = 0;
   always @(negedge sclk) if (rises < 16) sdata = adc_word[15 - rises];
   always @(posedge sclk) begin
      if (csn === 1'b0) rises++;
      else if (csn === 1'b1 && !rst) bad_rise++;
   end
   always @(negedge clk) if (csn === 1'b0) low_cnt++;
   always @(posedge csn) begin
      last_rises = rises; rises = 0;
      last_low = low_cnt; low_cnt = 0;
      if (adc_q.size() > 0) adc_word = adc_q.pop_front();
   end

   // ADC model B: fixed word
   logic [15:0] adc_word_b = 16'h0;
   int rises_b = 0, last_rises_b = 0, low_cnt_b = 0, last_low_b = 0, bad_rise_b = 0;
   always @(negedge sclk_b) if (rises_b < 16) sdata_b = adc_word_b[15 - rises_b];
   always @(posedge sclk_b) begin
      if (csn_b === 1'b0) rises_b++;
      else if (csn_b === 1'b1 && !rst) bad_rise_b++;
   end
   always @(negedge clk) if (csn_b === 1'b0) low_cnt_b++;
   always @(posedge csn_b) begin
      last_rises_b = rises_b; rises_b = 0;
      last_low_b = low_cnt_b; low_cnt_b = 0;
   end

   // expected results, one framed word per completed frame
   logic [15:0] exp_q[$];

   // wire order: 2 leading zeros, D11..D0, 2 trailing zeros
   function automatic logic [15:0] frame_word(input logic [1:0] lead, input logic [11:0] d,
                                              input logic [1:0] trail);
      return {lead, d, trail};
   endfunction

   function automatic logic [11:0] ref_sample(input logic [15:0] w);
      return w[13:2];
   endfunction

   function automatic logic ref_err(input logic [15:0] w);
      return (w[15:14] != 2'b00) || (w[1:0] != 2'b00);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pulse(input bit sel_b, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         step();
         if ((sel_b ? valid_b : valid) === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic check_pulse(input string tag);
      logic [15:0] w;
      w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      chk({tag, "_sample"}, 32'(smp), 32'(ref_sample(w)));
      chk({tag, "_err"}, 32'(err), 32'(ref_err(w)));
      chk({tag, "_sclk_rises"}, last_rises, 16);
      chk({tag, "_csn_low"}, last_low, 32);
   endtask

   initial begin
      int at, prev, entry, pulses, busy;
      logic [15:0] w;

      rst = 1'b1;
      repeat (3) step();
      chk("rst_csn", 32'(csn), 1);
      chk("rst_sclk", 32'(sclk), 1);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_sample", 32'(smp), 0);
      chk("rst_err", 32'(err), 0);

      adc_word = frame_word(2'b00, 12'hA5C, 2'b00);
      exp_q.push_back(adc_word);
      w = frame_word(2'b00, 12'hFFF, 2'b00); adc_q.push_back(w); exp_q.push_back(w);
      w = frame_word(2'b00, 12'h000, 2'b00); adc_q.push_back(w); exp_q.push_back(w);
      w = frame_word(2'b00, 12'h801, 2'b00); adc_q.push_back(w); exp_q.push_back(w);
      w = frame_word(2'b01, 12'h123, 2'b00); adc_q.push_back(w); exp_q.push_back(w);
      // four random frames, then en-drop, re-enable, toggle frames
      for (int i = 0; i < 7; i++) begin
         w = 16'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            w[15:14] = 2'b00;
            w[1:0]   = 2'b00;
         end
         adc_q.push_back(w);
         exp_q.push_back(w);
      end
      w = 16'($urandom); adc_q.push_back(w);          // aborted by rst, never delivered
      w = frame_word(2'b00, 12'($urandom), 2'b00); adc_q.push_back(w); exp_q.push_back(w);

      rst = 1'b0;
      en  = 1'b1;
      entry = cyc + 1;
      wait_pulse(1'b0, 100, at);
      chk("first_latency", at - entry, LAT);
      check_pulse("a5c");
      prev = at;
      step();
      chk("valid_one_cycle", 32'(valid), 0);
      chk("err_one_cycle", 32'(err), 0);
      chk("sample_hold", 32'(smp), 32'h0A5C);

      for (int i = 0; i < 8; i++) begin
         wait_pulse(1'b0, 100, at);
         chk("period", at - prev, FC);
         check_pulse("seq");
         prev = at;
      end

      // drop en at fcnt=10 of the following frame
      while (cyc < prev + (FC - LAT) + 10) step();
      en = 1'b0;
      wait_pulse(1'b0, 100, at);
      chk("endrop_period", at - prev, FC);
      check_pulse("endrop");
      pulses = 0;
      busy = 0;
      repeat (150) begin
         step();
         if (valid !== 1'b0) pulses++;
         if (csn !== 1'b1 || sclk !== 1'b1) busy++;
      end
      chk("idle_pulses", pulses, 0);
      chk("idle_lines", busy, 0);

      en = 1'b1;
      entry = cyc + 1;
      wait_pulse(1'b0, 100, at);
      chk("reenable_latency", at - entry, LAT);
      check_pulse("reenable");
      prev = at;

      // 1->0->1 within a frame must not disturb the cadence
      while (cyc < prev + 5) step();
      en = 1'b0;
      while (cyc < prev + 8) step();
      en = 1'b1;
      wait_pulse(1'b0, 100, at);
      chk("toggle_period", at - prev, FC);
      check_pulse("toggle");
      prev = at;

      // rst at fcnt=20 aborts the frame
      while (cyc < prev + (FC - LAT) + 20) step();
      rst = 1'b1;
      step();
      chk("abort_csn", 32'(csn), 1);
      chk("abort_sclk", 32'(sclk), 1);
      chk("abort_sample", 32'(smp), 0);
      chk("abort_valid", 32'(valid), 0);
      rst = 1'b0;
      entry = cyc + 1;
      wait_pulse(1'b0, 100, at);
      chk("fresh_latency", at - entry, LAT);
      check_pulse("fresh");

      // overridden parameters
      adc_word_b = frame_word(2'b00, 12'h3C5, 2'b00);
      en_b = 1'b1;
      entry = cyc + 1;
      wait_pulse(1'b1, 100, at);
      chk("b_latency", at - entry, LAT_B);
      chk("b_sample", 32'(smp_b), 32'h03C5);
      chk("b_err", 32'(err_b), 0);
      chk("b_sclk_rises", last_rises_b, 16);
      chk("b_csn_low", last_low_b, 32);
      prev = at;
      wait_pulse(1'b1, 100, at);
      chk("b_period", at - prev, FC_B);
      chk("b_sample2", 32'(smp_b), 32'h03C5);

      chk("a_sclk_while_csn_high", bad_rise, 0);
      chk("b_sclk_while_csn_high", bad_rise_b, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
